// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the matrix stream controller.
package matrix_pkg;

   localparam int unsigned DW        = 8;
   localparam int unsigned N_DEFAULT = 3;
   localparam int unsigned ELEMS     = N_DEFAULT * N_DEFAULT;

   typedef enum logic [1:0] {
      StLoadA,
      StLoadB,
      StCapture,
      StDrain
   } state_e;

endpackage

// File: rtl/matrix_stream_controller.sv
// Streams A and B into registers feeding an external multiplier, captures the
// product one cycle after the last B element and drains it row-major.
module matrix_stream_controller #(
   parameter int unsigned N  = matrix_pkg::N_DEFAULT,
   parameter int unsigned DW = matrix_pkg::DW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DW-1:0]     in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [N*N*DW-1:0] a_flat,
   output logic [N*N*DW-1:0] b_flat,
   input  logic [N*N*DW-1:0] c_flat,
   output logic [DW-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy
);
   import matrix_pkg::*;

   localparam int unsigned NUM_ELEMS = N * N;
   localparam int unsigned CW        = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
   localparam logic [CW-1:0] LAST    = CW'(NUM_ELEMS - 1);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N*N*DW-1:0]   a_q, b_q, c_q;
   logic                a_we, b_we, c_we;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_we      = 1'b0;
      b_we      = 1'b0;
      c_we      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      busy      = !(state_q == StLoadA && cnt_q == '0);
      unique case (state_q)
         StLoadA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_we = 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = StLoadB;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StLoadB: begin
            in_ready = 1'b1;
            if (in_valid) begin
               b_we = 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = StCapture;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         // The multiplier has had a full cycle to settle on the final B element.
         StCapture: begin
            c_we    = 1'b1;
            state_d = StDrain;
         end
         StDrain: begin
            out_valid = 1'b1;
            out_data  = c_q[cnt_q*DW +: DW];
            out_last  = (cnt_q == LAST);
            if (out_ready) begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = StLoadA;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = StLoadA;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoadA;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (a_we) a_q[cnt_q*DW +: DW] <= in_data;
         if (b_we) b_q[cnt_q*DW +: DW] <= in_data;
         if (c_we) c_q <= c_flat;
      end
   end

   assign a_flat = a_q;
   assign b_flat = b_q;

endmodule

// File: tb/tb_matrix_stream_controller.sv
// Self-checking bench: behavioural multiplier sibling plus a matrix-product reference model.
module tb_matrix_stream_controller;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned NE = N * N;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic [NE*DW-1:0]  a_flat, b_flat, c_flat;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] in_q[$];
   logic [7:0] exp_d[$];
   bit         exp_l[$];
   logic [7:0] got_d[$];
   bit         got_l[$];
   int lat_n, lat_err, stab_err, rdy_err, busy_low;

   matrix_stream_controller #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .c_flat    (c_flat),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Combinational multiplier stage sitting beside the controller.
   function automatic logic [NE*DW-1:0] mul_flat(input logic [NE*DW-1:0] a,
                                                 input logic [NE*DW-1:0] b);
      logic [NE*DW-1:0] c;
      int s;
      c = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++)
               s += int'(a[(i*N+k)*DW +: DW]) * int'(b[(k*N+j)*DW +: DW]);
            c[(i*N+j)*DW +: DW] = s[DW-1:0];
         end
      return c;
   endfunction

   assign c_flat = mul_flat(a_flat, b_flat);

   task automatic clear_jobs();
      in_q.delete();
      exp_d.delete();
      exp_l.delete();
   endtask

   // Reference model: queue the 18 inputs and the nine expected results of C = A*B mod 256.
   task automatic add_job(input logic [7:0] a[9], input logic [7:0] b[9]);
      int s;
      for (int i = 0; i < 9; i++) in_q.push_back(a[i]);
      for (int i = 0; i < 9; i++) in_q.push_back(b[i]);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int k = 0; k < 3; k++) s += int'(a[r*3+k]) * int'(b[k*3+c]);
            exp_d.push_back(8'(s % 256));
            exp_l.push_back(r == 2 && c == 2);
         end
   endtask

   // gap: 0 continuous, 1 alternate, 2 random; rdy: 0 always, 1 pattern 1,0,0, 2 random.
   task automatic run_jobs(input int gap, input int rdy, input bit junk);
      int in_idx = 0, out_cnt = 0, cyc = 0, lastb = -1;
      int nexp = exp_d.size();
      bit ready_exp, prev_stall = 0, prev_l = 0, acc_in, acc_out, cap_l;
      logic [7:0] prev_d = '0, cap_d;
      got_d.delete();
      got_l.delete();
      lat_n = 0; lat_err = 0; stab_err = 0; rdy_err = 0; busy_low = 0;
      while (out_cnt < nexp && cyc < 200 * (nexp / 9 + 1)) begin
         ready_exp = (in_idx - 18 * (out_cnt / 9)) < 18;
         if (in_idx < in_q.size()) begin
            in_valid = (gap == 0) || (gap == 1 && cyc % 2 == 0) ||
                       (gap == 2 && $urandom_range(1, 0) == 1);
            in_data  = in_q[in_idx];
         end else begin
            in_valid = junk ? 1'($urandom_range(1, 0)) : 1'b0;
            in_data  = 8'($urandom);
         end
         out_ready = (rdy == 0) ? 1'b1 : (rdy == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1, 0));
         #1;
         if (in_ready !== ready_exp) rdy_err++;
         if (in_idx > 0 && busy === 1'b0) busy_low++;
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l))
            stab_err++;
         if (out_valid === 1'b1 && lastb >= 0) begin
            lat_n++;
            if (cyc - lastb != 2) lat_err++;
            lastb = -1;
         end
         acc_in     = in_valid && in_ready === 1'b1;
         acc_out    = out_valid === 1'b1 && out_ready;
         prev_stall = out_valid === 1'b1 && !out_ready;
         prev_d     = out_data;
         prev_l     = out_last;
         cap_d      = out_data;
         cap_l      = out_last;
         @(posedge clk);
         if (acc_in) begin
            in_idx++;
            if (in_idx % 18 == 0) lastb = cyc;
         end
         if (acc_out) begin
            got_d.push_back(cap_d);
            got_l.push_back(cap_l);
            out_cnt++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total += 7;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
      if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      if (a_flat !== '0) begin bad++; $display("FAIL reset_a_flat got=%h want=0", a_flat); end
      if (b_flat !== '0) begin bad++; $display("FAIL reset_b_flat got=%h want=0", b_flat); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      logic [7:0] a[9], b[9];
      logic [NE*DW-1:0] pa, pb;
      for (int i = 0; i < 9; i++) begin
         a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
         b[i] = 8'(i + 1);
         pa[i*8 +: 8] = a[i];
         pb[i*8 +: 8] = b[i];
      end
      clear_jobs();
      add_job(a, b);
      run_jobs(0, 0, 1'b0);
      total++;
      if (got_d.size() != 9) begin bad++; $display("FAIL identity_count got=%0d want=9", got_d.size()); end
      for (int i = 0; i < 9 && i < got_d.size(); i++) begin
         total += 2;
         if (got_d[i] !== 8'(i + 1)) begin bad++; $display("FAIL identity_data[%0d] got=%0d want=%0d", i, got_d[i], i + 1); end
         if (got_l[i] !== (i == 8)) begin bad++; $display("FAIL identity_last[%0d] got=%b want=%b", i, got_l[i], i == 8); end
      end
      total += 6;
      if (lat_n != 1 || lat_err != 0) begin bad++; $display("FAIL identity_latency got=%0d bad of %0d want=0 of 1", lat_err, lat_n); end
      if (busy_low != 0) begin bad++; $display("FAIL identity_busy got=%0d low cycles want=0", busy_low); end
      if (rdy_err != 0) begin bad++; $display("FAIL identity_in_ready got=%0d errors want=0", rdy_err); end
      if (a_flat !== pa) begin bad++; $display("FAIL identity_a_retained got=%h want=%h", a_flat, pa); end
      if (b_flat !== pb) begin bad++; $display("FAIL identity_b_retained got=%h want=%h", b_flat, pb); end
      if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL identity_idle got=%b%b want=01", busy, in_ready); end
   endtask

   task automatic test_overflow();
      logic [7:0] a[9], b[9];
      for (int i = 0; i < 9; i++) begin a[i] = 8'd16; b[i] = 8'd16; end
      clear_jobs();
      add_job(a, b);
      run_jobs(0, 0, 1'b0);
      total++;
      if (got_d.size() != 9) begin bad++; $display("FAIL overflow_count got=%0d want=9", got_d.size()); end
      for (int i = 0; i < got_d.size(); i++) begin
         total++;
         if (got_d[i] !== 8'd0) begin bad++; $display("FAIL overflow_data[%0d] got=%0d want=0", i, got_d[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] a[9], b[9];
      for (int i = 0; i < 9; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
      clear_jobs();
      add_job(a, b);
      run_jobs(0, 1, 1'b0);
      total += 2;
      if (got_d.size() != 9) begin bad++; $display("FAIL backpressure_count got=%0d want=9", got_d.size()); end
      if (stab_err != 0) begin bad++; $display("FAIL backpressure_stable got=%0d changes want=0", stab_err); end
      for (int i = 0; i < got_d.size(); i++) begin
         total += 2;
         if (got_d[i] !== exp_d[i]) begin bad++; $display("FAIL backpressure_data[%0d] got=%0d want=%0d", i, got_d[i], exp_d[i]); end
         if (got_l[i] !== exp_l[i]) begin bad++; $display("FAIL backpressure_last[%0d] got=%b want=%b", i, got_l[i], exp_l[i]); end
      end
   endtask

   task automatic test_gapped();
      logic [7:0] a[9], b[9];
      for (int i = 0; i < 9; i++) begin a[i] = (i % 4 == 0) ? 8'd1 : 8'd0; b[i] = 8'(i + 1); end
      clear_jobs();
      add_job(a, b);
      run_jobs(1, 0, 1'b1);
      total += 4;
      if (got_d.size() != 9) begin bad++; $display("FAIL gapped_count got=%0d want=9", got_d.size()); end
      if (rdy_err != 0) begin bad++; $display("FAIL gapped_in_ready got=%0d errors want=0", rdy_err); end
      if (lat_n != 1 || lat_err != 0) begin bad++; $display("FAIL gapped_latency got=%0d bad of %0d want=0 of 1", lat_err, lat_n); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL gapped_reentry_ready got=%b want=1", in_ready); end
      for (int i = 0; i < got_d.size(); i++) begin
         total++;
         if (got_d[i] !== 8'(i + 1) || got_l[i] !== (i == 8)) begin
            bad++; $display("FAIL gapped_data[%0d] got=%0d/%b want=%0d/%b", i, got_d[i], got_l[i], i + 1, i == 8);
         end
      end
   endtask

   task automatic test_reset_midjob();
      logic [7:0] a[9], b[9];
      int stray = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(255, 1));
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL midjob_busy got=%b want=1", busy); end
      #2 rst_n = 1'b0;
      #1;
      total += 3;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midjob_reset_hs got=%b%b want=01", out_valid, in_ready); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midjob_reset_busy got=%b want=0", busy); end
      if (a_flat !== '0) begin bad++; $display("FAIL midjob_reset_a got=%h want=0", a_flat); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         out_ready = 1'b1;
         #1;
         if (out_valid !== 1'b0) stray++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      total++;
      if (stray != 0) begin bad++; $display("FAIL midjob_no_output got=%0d valid cycles want=0", stray); end
      for (int i = 0; i < 9; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
      clear_jobs();
      add_job(a, b);
      run_jobs(0, 0, 1'b0);
      total++;
      if (got_d.size() != 9) begin bad++; $display("FAIL midjob_count got=%0d want=9", got_d.size()); end
      for (int i = 0; i < got_d.size(); i++) begin
         total++;
         if (got_d[i] !== exp_d[i]) begin bad++; $display("FAIL midjob_data[%0d] got=%0d want=%0d", i, got_d[i], exp_d[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a[9], b[9], o[9];
      for (int i = 0; i < 9; i++) begin
         a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
         b[i] = 8'(i + 1);
         o[i] = 8'd1;
      end
      clear_jobs();
      add_job(a, b);
      add_job(o, o);
      run_jobs(0, 0, 1'b0);
      total += 3;
      if (got_d.size() != 18) begin bad++; $display("FAIL b2b_count got=%0d want=18", got_d.size()); end
      if (busy_low != 1) begin bad++; $display("FAIL b2b_busy_gap got=%0d cycles want=1", busy_low); end
      if (lat_n != 2 || lat_err != 0) begin bad++; $display("FAIL b2b_latency got=%0d bad of %0d want=0 of 2", lat_err, lat_n); end
      for (int i = 0; i < got_d.size() && i < 18; i++) begin
         total++;
         if (got_d[i] !== ((i < 9) ? 8'(i + 1) : 8'd3)) begin
            bad++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", i, got_d[i], (i < 9) ? i + 1 : 3);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] a[9], b[9];
      clear_jobs();
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 9; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
         add_job(a, b);
      end
      run_jobs(2, 2, 1'b1);
      total += 4;
      if (got_d.size() != 27) begin bad++; $display("FAIL random_count got=%0d want=27", got_d.size()); end
      if (stab_err != 0) begin bad++; $display("FAIL random_stable got=%0d changes want=0", stab_err); end
      if (rdy_err != 0) begin bad++; $display("FAIL random_in_ready got=%0d errors want=0", rdy_err); end
      if (lat_n != 3 || lat_err != 0) begin bad++; $display("FAIL random_latency got=%0d bad of %0d want=0 of 3", lat_err, lat_n); end
      for (int i = 0; i < got_d.size() && i < 27; i++) begin
         total++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            bad++; $display("FAIL random_data[%0d] got=%0d/%b want=%0d/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_identity();
      test_overflow();
      test_backpressure();
      test_gapped();
      test_reset_midjob();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
